mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised memory writeback stage between the cache data read and the register-file write port.
- Per thread, it selects one word from the returned cache line using that thread's word offset and zeroes masked-off lanes.
- Results are buffered in a DEPTH-entry FIFO, so a busy RF write port back-pressures the cache pipe instead of dropping data.
- It issues the scoreboard positive feedback (warp/scb ID and mask) when an entry retires.

Parameters:
NUM_THREADS, 8, lanes per warp
WORD_W, 32, bits per lane/word
LINE_WORDS, 8, words per cache line (power of 2); OFS_W = $clog2(LINE_WORDS)
DEPTH, 4, FIFO entries (power of 2, >=2)
WARP_ID_W, 3, warp ID width
SCB_ID_W, 2, scoreboard slot ID width
REG_ADDR_W, 5, register address width

Ports:
clk in 1 clock, all state on rising edge
resetb in 1 asynchronous active-low reset
in_valid in 1 request valid
in_ready out 1 stage can accept
in_reg_write in 1 load: write RF
in_fb_valid in 1 non-writing op (store) still needs feedback
in_warp_id in WARP_ID_W warp
in_scb_id in SCB_ID_W scoreboard slot
in_line_data in LINE_WORDS*WORD_W cache line, word 0 at LSBs
in_reg_addr in REG_ADDR_W destination register
in_thread_mask in NUM_THREADS active lanes
in_word_offset in NUM_THREADS*OFS_W per-lane word index, lane 0 at LSBs
in_size in 2 sub-word size (feature only)
in_signed in 1 sign-extend (feature only)
in_byte_ofs in NUM_THREADS*2 per-lane byte index (feature only)
rf_ready in 1 RF write port free this cycle
rf_write_o out 1 RF write strobe
rf_addr_o out REG_ADDR_W RF address
rf_mask_o out NUM_THREADS RF lane enables
rf_data_o out NUM_THREADS*WORD_W RF data, lane 0 at LSBs
fb_valid_o out 1 feedback pulse
fb_mask_o out NUM_THREADS feedback mask
fb_warp_id_o out WARP_ID_W feedback warp
fb_scb_id_o out SCB_ID_W feedback slot
occupancy_o out $clog2(DEPTH+1) valid entries

Behaviour:
- Accept: a request is accepted when in_valid && in_ready at a clock edge. in_ready = (count < DEPTH); there is no pass-through when full.
- Drop: an accepted request with in_reg_write=0 and in_fb_valid=0 is discarded and not enqueued.
- Lane select: lane i data = in_line_data word[in_word_offset[i]] when in_thread_mask[i]=1, else 0. Computed combinationally at the input and stored in the FIFO entry.
- Entry contents: reg_write, fb, warp, scb, addr, mask, data.
- Latency: accepted at edge T -> visible at the head/outputs after edge T (1 cycle minimum); FIFO order is preserved.
- Head outputs: all combinational from registered head state. All outputs are 0 when empty.
  - rf_write_o = head_valid && head.reg_write.
  - rf_addr_o, rf_mask_o and rf_data_o come from the head.
- Retire: occurs when head_valid && (!head.reg_write || rf_ready). A non-writing entry retires without rf_ready.
- Feedback: fb_valid_o = retire && (head.reg_write || head.fb). This is a one-cycle pulse per entry. fb_mask_o, fb_warp_id_o and fb_scb_id_o equal the head fields when fb_valid_o=1, else 0.
- Pointers: read/write pointers wrap modulo DEPTH. count is updated +1 on push only, -1 on retire only, unchanged on simultaneous push and retire.
- Full: push and retire in the same cycle while full -> retire happens, push is refused (in_ready=0).
- Back-pressure: rf_ready held 0 with a writing head -> head, rf_write_o and data are held stable; no feedback.
- Reset: resetb low asynchronously clears count and pointers.
  - All outputs go to 0 except in_ready, which is 1.
  - Entries in flight are flushed with no feedback.
  - Inputs are ignored while resetb=0.
- occupancy_o = count.

Optional Feature:
MEM_WB_SUBWORD_EN:
- Defined (requires WORD_W=32): after word select, each lane extracts a sub-word by in_size.
  - 00 = word.
  - 01 = half at byte (in_byte_ofs[i] & 2).
  - 10 = byte at in_byte_ofs[i].
  - 11 = treated as word.
  - Extension: sign-extended if in_signed=1, else zero-extended.
  - Extraction happens before enqueue; masked lanes are still 0.
- Undefined: in_size, in_signed and in_byte_ofs are ignored; full word only.

Test Plan:
1. Line words k = 0x1000_0000+k, offsets lane i = 7-i, mask 0xFF, reg_write=1, addr 5, rf_ready=1 -> next cycle rf_write_o=1, addr 5, lane i = 0x1000_0007-i; fb_valid_o=1, warp/scb echoed, mask 0xFF.
2. Mask 0x0F, offsets all 3 -> lanes 0-3 = word 3, lanes 4-7 = 0; fb_mask_o=0x0F.
3. rf_ready=0, push 5 loads back-to-back -> in_ready=0 after 4, occupancy_o=4, rf_write_o held on first entry; raise rf_ready -> entries retire in order, one per cycle, one fb pulse each.
4. Store (reg_write=0, fb_valid=1) queued behind a blocked load -> no retire until rf_ready=1; store then retires the cycle after the load with rf_write_o=0, fb_valid_o=1. Request with both 0 -> occupancy_o unchanged.
5. Full FIFO with rf_ready=1 and in_valid=1 -> in_ready=0 that cycle, count 4->3, next cycle accepted; pointers wrap correctly over 12 mixed pushes.
6. resetb pulsed low with 3 entries queued -> immediately occupancy_o=0, rf_write_o=0, fb_valid_o=0, in_ready=1; no feedback for flushed entries. With MEM_WB_SUBWORD_EN: word 0x0000_80FF, size=10, byte_ofs=0, signed=1 -> lane = 0xFFFF_FFFF; size=01, byte_ofs=2 -> lane = 0x0000_0000.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory writeback stage: per-lane word select from a cache line, DEPTH-entry FIFO toward the RF write port,
// scoreboard feedback on retire. Define MEM_WB_SUBWORD_EN for byte/half extraction with optional sign extension.
module mem_wb_stage #(
  parameter int NUM_THREADS = 8,
  parameter int WORD_W      = 32,
  parameter int LINE_WORDS  = 8,
  parameter int DEPTH       = 4,
  parameter int WARP_ID_W   = 3,
  parameter int SCB_ID_W    = 2,
  parameter int REG_ADDR_W  = 5,
  localparam int OFS_W      = $clog2(LINE_WORDS),
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            resetb,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_reg_write,
  input  logic                            in_fb_valid,
  input  logic [WARP_ID_W-1:0]            in_warp_id,
  input  logic [SCB_ID_W-1:0]             in_scb_id,
  input  logic [LINE_WORDS*WORD_W-1:0]    in_line_data,
  input  logic [REG_ADDR_W-1:0]           in_reg_addr,
  input  logic [NUM_THREADS-1:0]          in_thread_mask,
  input  logic [NUM_THREADS*OFS_W-1:0]    in_word_offset,
  input  logic [1:0]                      in_size,
  input  logic                            in_signed,
  input  logic [NUM_THREADS*2-1:0]        in_byte_ofs,
  input  logic                            rf_ready,
  output logic                            rf_write_o,
  output logic [REG_ADDR_W-1:0]           rf_addr_o,
  output logic [NUM_THREADS-1:0]          rf_mask_o,
  output logic [NUM_THREADS*WORD_W-1:0]   rf_data_o,
  output logic                            fb_valid_o,
  output logic [NUM_THREADS-1:0]          fb_mask_o,
  output logic [WARP_ID_W-1:0]            fb_warp_id_o,
  output logic [SCB_ID_W-1:0]             fb_scb_id_o,
  output logic [CNT_W-1:0]                occupancy_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic                          reg_write;
    logic                          fb;
    logic [WARP_ID_W-1:0]          warp;
    logic [SCB_ID_W-1:0]           scb;
    logic [REG_ADDR_W-1:0]         addr;
    logic [NUM_THREADS-1:0]        mask;
    logic [NUM_THREADS*WORD_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            in_ent;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_valid, push, retire;

  function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_WORDS*WORD_W-1:0] line,
                                                 input logic [OFS_W-1:0] ofs);
    return line[int'(ofs)*WORD_W +: WORD_W];
  endfunction

`ifdef MEM_WB_SUBWORD_EN
  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] bofs);
    logic [15:0] h;
    logic [7:0]  b;
    h = bofs[1] ? w[31:16] : w[15:0];
    b = w[int'(bofs)*8 +: 8];
    case (size)
      2'b01:   return {{(WORD_W-16){sgn & h[15]}}, h};
      2'b10:   return {{(WORD_W-8){sgn & b[7]}}, b};
      default: return w;
    endcase
  endfunction
`else
  logic unused_subword;
  assign unused_subword = ^{in_size, in_signed, in_byte_ofs};
`endif

  always_comb begin
    in_ent           = '0;
    in_ent.reg_write = in_reg_write;
    in_ent.fb        = in_fb_valid;
    in_ent.warp      = in_warp_id;
    in_ent.scb       = in_scb_id;
    in_ent.addr      = in_reg_addr;
    in_ent.mask      = in_thread_mask;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (in_thread_mask[i]) begin
`ifdef MEM_WB_SUBWORD_EN
        in_ent.data[i*WORD_W +: WORD_W] =
          sub_word(sel_word(in_line_data, in_word_offset[i*OFS_W +: OFS_W]),
                   in_size, in_signed, in_byte_ofs[i*2 +: 2]);
`else
        in_ent.data[i*WORD_W +: WORD_W] = sel_word(in_line_data, in_word_offset[i*OFS_W +: OFS_W]);
`endif
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q != FULL);
  // Requests that neither write nor need feedback are consumed without taking a slot.
  assign push       = in_valid && in_ready && (in_reg_write || in_fb_valid);
  assign retire     = head_valid && (!head.reg_write || rf_ready);

  always_comb begin
    wr_ptr_d = push   ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end

  assign rf_write_o   = head_valid && head.reg_write;
  assign rf_addr_o    = head_valid ? head.addr : '0;
  assign rf_mask_o    = head_valid ? head.mask : '0;
  assign rf_data_o    = head_valid ? head.data : '0;
  assign fb_valid_o   = retire && (head.reg_write || head.fb);
  assign fb_mask_o    = fb_valid_o ? head.mask : '0;
  assign fb_warp_id_o = fb_valid_o ? head.warp : '0;
  assign fb_scb_id_o  = fb_valid_o ? head.scb : '0;
  assign occupancy_o  = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mem_wb_stage;
  localparam int NT = 8, WW = 32, LW = 8, OW = 3, DEPTH = 4, WI = 3, SI = 2, RA = 5, CW = 3;
`ifdef MEM_WB_SUBWORD_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic in_valid = 1'b0, in_ready, in_reg_write = 1'b0, in_fb_valid = 1'b0;
  logic [WI-1:0] in_warp_id = '0;
  logic [SI-1:0] in_scb_id = '0;
  logic [LW*WW-1:0] in_line_data = '0;
  logic [RA-1:0] in_reg_addr = '0;
  logic [NT-1:0] in_thread_mask = '0;
  logic [NT*OW-1:0] in_word_offset = '0;
  logic [1:0] in_size = '0;
  logic in_signed = 1'b0;
  logic [NT*2-1:0] in_byte_ofs = '0;
  logic rf_ready = 1'b0;
  logic rf_write_o, fb_valid_o;
  logic [RA-1:0] rf_addr_o;
  logic [NT-1:0] rf_mask_o, fb_mask_o;
  logic [NT*WW-1:0] rf_data_o;
  logic [WI-1:0] fb_warp_id_o;
  logic [SI-1:0] fb_scb_id_o;
  logic [CW-1:0] occupancy_o;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .resetb(resetb), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_fb_valid(in_fb_valid), .in_warp_id(in_warp_id),
    .in_scb_id(in_scb_id), .in_line_data(in_line_data), .in_reg_addr(in_reg_addr),
    .in_thread_mask(in_thread_mask), .in_word_offset(in_word_offset), .in_size(in_size),
    .in_signed(in_signed), .in_byte_ofs(in_byte_ofs), .rf_ready(rf_ready),
    .rf_write_o(rf_write_o), .rf_addr_o(rf_addr_o), .rf_mask_o(rf_mask_o), .rf_data_o(rf_data_o),
    .fb_valid_o(fb_valid_o), .fb_mask_o(fb_mask_o), .fb_warp_id_o(fb_warp_id_o),
    .fb_scb_id_o(fb_scb_id_o), .occupancy_o(occupancy_o)
  );

  typedef struct packed {
    logic          rw;
    logic          fb;
    logic [WI-1:0] warp;
    logic [SI-1:0] scb;
    logic [RA-1:0] addr;
    logic [NT-1:0] mask;
    logic [NT*WW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int checks = 0, errors = 0, dut_fb_pulses = 0;

  always @(negedge clk) if (fb_valid_o === 1'b1) dut_fb_pulses++;

  // Reference lane value: pick the word, then (optionally) cut a byte/half out arithmetically.
  function automatic logic [NT*WW-1:0] model_data(input logic [LW*WW-1:0] line, input logic [NT*OW-1:0] ofs,
      input logic [NT-1:0] mask, input logic [1:0] size, input logic sgn, input logic [NT*2-1:0] bofs);
    logic [WW-1:0] words [LW];
    logic [NT*WW-1:0] r;
    longint v;
    r = '0;
    for (int k = 0; k < LW; k++) words[k] = line[k*WW +: WW];
    for (int i = 0; i < NT; i++) begin
      v = words[ofs[i*OW +: OW]];
      if (SUB_EN && size == 2'b10) begin
        v = (v >> (8 * bofs[i*2 +: 2])) % 256;
        if (sgn && v >= 128) v = v - 256;
      end else if (SUB_EN && size == 2'b01) begin
        v = (v >> (16 * bofs[i*2+1])) % 65536;
        if (sgn && v >= 32768) v = v - 65536;
      end
      if (mask[i]) r[i*WW +: WW] = v[WW-1:0];
    end
    return r;
  endfunction

  function automatic ent_t cur_req();
    ent_t e;
    e.rw = in_reg_write; e.fb = in_fb_valid; e.warp = in_warp_id; e.scb = in_scb_id;
    e.addr = in_reg_addr; e.mask = in_thread_mask;
    e.data = model_data(in_line_data, in_word_offset, in_thread_mask, in_size, in_signed, in_byte_ofs);
    return e;
  endfunction

  function automatic logic [LW*WW-1:0] rand_line();
    logic [LW*WW-1:0] r;
    for (int k = 0; k < LW; k++) r[k*WW +: WW] = $urandom;
    return r;
  endfunction

  function automatic logic [NT*OW-1:0] rand_ofs();
    logic [NT*OW-1:0] r;
    for (int i = 0; i < NT; i++) r[i*OW +: OW] = OW'($urandom);
    return r;
  endfunction

  function automatic logic [LW*WW-1:0] line_k();
    logic [LW*WW-1:0] r;
    for (int k = 0; k < LW; k++) r[k*WW +: WW] = 32'h1000_0000 + k;
    return r;
  endfunction

  function automatic logic [NT*OW-1:0] ofs_rev();
    logic [NT*OW-1:0] r;
    for (int i = 0; i < NT; i++) r[i*OW +: OW] = OW'(NT - 1 - i);
    return r;
  endfunction

  task automatic set_req(input logic v, input logic rw, input logic fb, input logic [RA-1:0] addr,
                         input logic [NT-1:0] mask, input logic [NT*OW-1:0] ofs, input logic [LW*WW-1:0] line);
    in_valid = v; in_reg_write = rw; in_fb_valid = fb; in_reg_addr = addr;
    in_thread_mask = mask; in_word_offset = ofs; in_line_data = line;
    in_warp_id = WI'($urandom); in_scb_id = SI'($urandom);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_reg_write = 1'b0; in_fb_valid = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    logic ret, acc;
    ent_t e;
    e   = cur_req();
    ret = (mq.size() > 0) && (!mq[0].rw || rf_ready);
    acc = in_valid && (mq.size() < DEPTH);
    @(posedge clk);
    if (resetb) begin
      if (ret) void'(mq.pop_front());
      if (acc && (e.rw || e.fb)) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b0; idle(); rf_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (rf_write_o !== 1'b0) begin errors++; $display("FAIL reset_rf_write: got %b want 0", rf_write_o); end
    checks++; if (fb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fb: got %b want 0", fb_valid_o); end
    resetb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [NT*WW-1:0] exp_d;
    logic [WI-1:0] w;
    logic [SI-1:0] s;
    rf_ready = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 5'd5, 8'hFF, ofs_rev(), line_k());
    w = in_warp_id; s = in_scb_id;
    for (int i = 0; i < NT; i++) exp_d[i*WW +: WW] = 32'h1000_0007 - i;
    tick(); idle();
    @(negedge clk);
    checks++; if (rf_write_o !== 1'b1) begin errors++; $display("FAIL basic_rf_write: got %b want 1", rf_write_o); end
    checks++; if (rf_addr_o !== 5'd5) begin errors++; $display("FAIL basic_rf_addr: got %0d want 5", rf_addr_o); end
    checks++; if (rf_data_o !== exp_d) begin errors++; $display("FAIL basic_rf_data: got %h want %h", rf_data_o, exp_d); end
    checks++; if (fb_valid_o !== 1'b1) begin errors++; $display("FAIL basic_fb_valid: got %b want 1", fb_valid_o); end
    checks++; if (fb_mask_o !== 8'hFF) begin errors++; $display("FAIL basic_fb_mask: got %h want ff", fb_mask_o); end
    checks++; if (fb_warp_id_o !== w || fb_scb_id_o !== s) begin
      errors++; $display("FAIL basic_fb_ids: got %0d/%0d want %0d/%0d", fb_warp_id_o, fb_scb_id_o, w, s); end
    tick();
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL basic_drain: got %0d want 0", occupancy_o); end
  endtask

  task automatic test_mask();
    logic [NT*WW-1:0] exp_d;
    exp_d = '0;
    for (int i = 0; i < 4; i++) exp_d[i*WW +: WW] = 32'h1000_0003;
    rf_ready = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 5'd9, 8'h0F, {NT{3'd3}}, line_k());
    tick(); idle();
    @(negedge clk);
    checks++; if (rf_data_o !== exp_d) begin errors++; $display("FAIL mask_data: got %h want %h", rf_data_o, exp_d); end
    checks++; if (fb_mask_o !== 8'h0F) begin errors++; $display("FAIL mask_fb_mask: got %h want 0f", fb_mask_o); end
    checks++; if (rf_mask_o !== 8'h0F) begin errors++; $display("FAIL mask_rf_mask: got %h want 0f", rf_mask_o); end
    tick();
  endtask

  task automatic test_backpressure();
    int p0;
    logic [NT*WW-1:0] first;
    p0 = dut_fb_pulses;
    rf_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b1, 1'b1, 1'b0, RA'(k + 1), 8'hFF, rand_ofs(), rand_line());
      @(negedge clk);
      checks++; if (in_ready !== (k < 4)) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", k, in_ready, k < 4); end
      tick();
    end
    idle();
    first = mq[0].data;
    @(negedge clk);
    checks++; if (occupancy_o !== 3'd4) begin errors++; $display("FAIL bp_occ: got %0d want 4", occupancy_o); end
    checks++; if (rf_write_o !== 1'b1 || rf_addr_o !== 5'd1) begin
      errors++; $display("FAIL bp_head: got wr=%b addr=%0d want wr=1 addr=1", rf_write_o, rf_addr_o); end
    checks++; if (fb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_fb: got %b want 0", fb_valid_o); end
    tick();
    @(negedge clk);
    checks++; if (rf_data_o !== first) begin errors++; $display("FAIL bp_hold: got %h want %h", rf_data_o, first); end
    tick();
    rf_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (rf_addr_o !== RA'(k + 1) || rf_data_o !== mq[0].data) begin
        errors++; $display("FAIL bp_order[%0d]: got addr=%0d want %0d", k, rf_addr_o, k + 1); end
      checks++; if (fb_valid_o !== 1'b1 || fb_warp_id_o !== mq[0].warp) begin
        errors++; $display("FAIL bp_fb[%0d]: got v=%b warp=%0d want v=1 warp=%0d", k, fb_valid_o, fb_warp_id_o, mq[0].warp); end
      tick();
    end
    checks++; if (dut_fb_pulses - p0 !== 4) begin errors++; $display("FAIL bp_pulses: got %0d want 4", dut_fb_pulses - p0); end
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL bp_drain: got %0d want 0", occupancy_o); end
  endtask

  task automatic test_store();
    int p0;
    logic [WI-1:0] lw, sw;
    logic [SI-1:0] ss;
    p0 = dut_fb_pulses;
    rf_ready = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 5'd7, 8'hFF, rand_ofs(), rand_line()); lw = in_warp_id; tick();
    set_req(1'b1, 1'b0, 1'b1, 5'd9, 8'hAA, rand_ofs(), rand_line()); sw = in_warp_id; ss = in_scb_id; tick();
    set_req(1'b1, 1'b0, 1'b0, 5'd3, 8'hFF, rand_ofs(), rand_line()); tick();
    idle();
    @(negedge clk);
    checks++; if (occupancy_o !== 3'd2) begin errors++; $display("FAIL store_drop_occ: got %0d want 2", occupancy_o); end
    tick();
    @(negedge clk);
    checks++; if (fb_valid_o !== 1'b0 || occupancy_o !== 3'd2) begin
      errors++; $display("FAIL store_blocked: got fb=%b occ=%0d want fb=0 occ=2", fb_valid_o, occupancy_o); end
    rf_ready = 1'b1; #1;
    checks++; if (rf_write_o !== 1'b1 || fb_valid_o !== 1'b1 || fb_warp_id_o !== lw) begin
      errors++; $display("FAIL store_load_ret: got wr=%b fb=%b warp=%0d want 1 1 %0d", rf_write_o, fb_valid_o, fb_warp_id_o, lw); end
    tick();
    @(negedge clk);
    checks++; if (rf_write_o !== 1'b0 || fb_valid_o !== 1'b1) begin
      errors++; $display("FAIL store_ret: got wr=%b fb=%b want wr=0 fb=1", rf_write_o, fb_valid_o); end
    checks++; if (fb_warp_id_o !== sw || fb_scb_id_o !== ss || fb_mask_o !== 8'hAA) begin
      errors++; $display("FAIL store_fb_fields: got %0d/%0d/%h want %0d/%0d/aa", fb_warp_id_o, fb_scb_id_o, fb_mask_o, sw, ss); end
    tick();
    checks++; if (dut_fb_pulses - p0 !== 2) begin errors++; $display("FAIL store_pulses: got %0d want 2", dut_fb_pulses - p0); end
  endtask

  task automatic test_full_wrap();
    rf_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 1'b1, 1'b0, RA'(k), 8'hFF, rand_ofs(), rand_line()); tick();
    end
    set_req(1'b1, 1'b1, 1'b0, 5'd20, 8'hFF, rand_ofs(), rand_line());
    rf_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || fb_valid_o !== 1'b1) begin
      errors++; $display("FAIL full_refuse: got rdy=%b fb=%b want rdy=0 fb=1", in_ready, fb_valid_o); end
    tick();
    @(negedge clk);
    checks++; if (occupancy_o !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_after: got occ=%0d rdy=%b want occ=3 rdy=1", occupancy_o, in_ready); end
    tick();
    @(negedge clk);
    checks++; if (occupancy_o !== 3'd3) begin errors++; $display("FAIL full_pushpop: got %0d want 3", occupancy_o); end
    idle();
    repeat (4) tick();
  endtask

  task automatic test_random();
    ent_t h;
    logic hv, ret;
    for (int c = 0; c < 400; c++) begin
      set_req($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), RA'($urandom), NT'($urandom), rand_ofs(), rand_line());
      in_size = 2'($urandom); in_signed = 1'($urandom); in_byte_ofs = 16'($urandom);
      rf_ready = $urandom_range(0, 9) < 6;
      @(negedge clk);
      hv = mq.size() > 0;
      h = hv ? mq[0] : '0;
      ret = hv && (!h.rw || rf_ready);
      checks++; if (occupancy_o !== CW'(mq.size())) begin errors++; $display("FAIL rnd_occ@%0d: got %0d want %0d", c, occupancy_o, mq.size()); end
      checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b", c, in_ready); end
      checks++; if (rf_write_o !== (hv && h.rw)) begin errors++; $display("FAIL rnd_rf_write@%0d: got %b want %b", c, rf_write_o, hv && h.rw); end
      checks++; if (rf_addr_o !== h.addr || rf_mask_o !== h.mask) begin
        errors++; $display("FAIL rnd_rf_addr_mask@%0d: got %0d/%h want %0d/%h", c, rf_addr_o, rf_mask_o, h.addr, h.mask); end
      checks++; if (rf_data_o !== h.data) begin errors++; $display("FAIL rnd_rf_data@%0d: got %h want %h", c, rf_data_o, h.data); end
      checks++; if (fb_valid_o !== ret) begin errors++; $display("FAIL rnd_fb_valid@%0d: got %b want %b", c, fb_valid_o, ret); end
      checks++; if (fb_mask_o !== (ret ? h.mask : '0) || fb_warp_id_o !== (ret ? h.warp : '0) || fb_scb_id_o !== (ret ? h.scb : '0)) begin
        errors++; $display("FAIL rnd_fb_fields@%0d: got %h/%0d/%0d", c, fb_mask_o, fb_warp_id_o, fb_scb_id_o); end
      tick();
    end
    idle(); in_size = 2'b00; in_signed = 1'b0; in_byte_ofs = '0; rf_ready = 1'b1;
    repeat (5) tick();
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL rnd_drain: got %0d want 0", occupancy_o); end
  endtask

`ifdef MEM_WB_SUBWORD_EN
  task automatic test_subword();
    logic [LW*WW-1:0] line;
    line = rand_line();
    line[WW-1:0] = 32'h0000_80FF;
    rf_ready = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 5'd1, 8'hFF, '0, line);
    in_size = 2'b10; in_byte_ofs = '0; in_signed = 1'b1;
    tick();
    set_req(1'b1, 1'b1, 1'b0, 5'd2, 8'hFF, '0, line);
    in_size = 2'b01; in_byte_ofs = {NT{2'b10}};
    @(negedge clk);
    checks++; if (rf_data_o !== {NT{32'hFFFF_FFFF}}) begin errors++; $display("FAIL sub_byte_signed: got %h", rf_data_o); end
    tick(); idle(); in_size = 2'b00; in_signed = 1'b0; in_byte_ofs = '0;
    @(negedge clk);
    checks++; if (rf_data_o !== '0) begin errors++; $display("FAIL sub_half_hi: got %h want 0", rf_data_o); end
    tick();
  endtask
`endif

  task automatic test_reset_flush();
    int p0;
    rf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b1, 1'b1, RA'(k), 8'hFF, rand_ofs(), rand_line()); tick();
    end
    idle();
    p0 = dut_fb_pulses;
    @(negedge clk);
    checks++; if (occupancy_o !== 3'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy_o); end
    resetb = 1'b0; #1;
    mq.delete();
    checks++; if (occupancy_o !== '0 || rf_write_o !== 1'b0) begin
      errors++; $display("FAIL flush_async: got occ=%0d wr=%b want 0 0", occupancy_o, rf_write_o); end
    checks++; if (fb_valid_o !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ctrl: got fb=%b rdy=%b want fb=0 rdy=1", fb_valid_o, in_ready); end
    set_req(1'b1, 1'b1, 1'b1, 5'd4, 8'hFF, rand_ofs(), rand_line());
    rf_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL flush_ignore_in: got %0d want 0", occupancy_o); end
    idle();
    @(negedge clk); resetb = 1'b1;
    @(posedge clk); #1;
    checks++; if (dut_fb_pulses !== p0 || occupancy_o !== '0) begin
      errors++; $display("FAIL flush_no_fb: got pulses=%0d occ=%0d want pulses=%0d occ=0", dut_fb_pulses, occupancy_o, p0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_backpressure();
    test_store();
    test_full_wrap();
    test_random();
`ifdef MEM_WB_SUBWORD_EN
    test_subword();
`endif
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
